// File: rtl/gate_chk_pkg.sv
// Shared types and helpers for the gate truth-table checker.
// Optional feature macro: GATE_CHK_STOP_ON_FAIL_EN.
package gate_chk_pkg;

    localparam int SETTLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic expected_bit(
        input logic [15:0] mask,
        input logic [3:0]  vec
    );
        return mask[vec];
    endfunction

endpackage

// File: rtl/gate_chk_settle_cnt.sv
// Loadable down-counter used to hold each vector for the settle time.
// Stops at zero; zero flag is combinational from the count.
module gate_chk_settle_cnt
    import gate_chk_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    output logic                zero
);

    logic [SETTLE_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Walks all input vectors of a gate, compares y to a truth table mask.
// Optional feature macro: GATE_CHK_STOP_ON_FAIL_EN (end run at first mismatch).
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter int                    N_IN          = 2,
    parameter logic [2**N_IN-1:0]    EXPECT_MASK   = 4'b1110,
    parameter int                    SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   drive,
    input  logic              dut_y,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail,
    output logic              fail_seen
);

    localparam logic [SETTLE_W-1:0] LOAD_VAL = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0]     LAST_VEC = '1;

    state_t          state;
    logic [N_IN-1:0] vec;
    logic            cnt_load;
    logic            cnt_zero;
    logic            mismatch;
    logic            last;

    assign mismatch = (dut_y != expected_bit(16'(EXPECT_MASK), 4'(vec)));

`ifdef GATE_CHK_STOP_ON_FAIL_EN
    assign last = (vec == LAST_VEC) || mismatch;
`else
    assign last = (vec == LAST_VEC);
`endif

    // Reload on run start and on every check so each vector gets a full settle.
    assign cnt_load = ((state == S_IDLE) && start) || (state == S_CHECK);

    assign drive = ((state == S_SETTLE) || (state == S_CHECK)) ? vec : '0;

    gate_chk_settle_cnt u_settle (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            vec        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
            fail_seen  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        fail_seen  <= 1'b0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_SETTLE;
                    end
                end
                (state == S_SETTLE): begin
                    if (cnt_zero) begin
                        state <= S_CHECK;
                    end
                end
                (state == S_CHECK): begin
                    if (mismatch) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_seen) begin
                            first_fail <= vec;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == '0);
                        state <= S_DONE;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= S_SETTLE;
                    end
                end
                (state == S_DONE): begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
